// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op-classification helpers for the sequential ALU.
// Nothing here depends on the datapath width.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpAdc  = 4'b0001,
    OpSub  = 4'b0010,
    OpSbc  = 4'b0011,
    OpAnd  = 4'b0100,
    OpOr   = 4'b0101,
    OpXor  = 4'b0110,
    OpAndn = 4'b0111,
    OpShl  = 4'b1000,
    OpShr  = 4'b1001,
    OpRol  = 4'b1010,
    OpRor  = 4'b1011,
    OpMul  = 4'b1100,
    OpMulh = 4'b1101,
    OpRsv0 = 4'b1110,
    OpRsv1 = 4'b1111
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } alu_state_e;

  function automatic logic op_is_mul(alu_op_e op);
    return (op == OpMul) || (op == OpMulh);
  endfunction

  // Shifts and rotates by 0 or 1 finish in the accept cycle.
  function automatic logic op_is_multicycle(alu_op_e op, logic count_gt1);
    case (op)
      OpShl, OpShr, OpRol, OpRor: return count_gt1;
      OpMul, OpMulh:              return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier. The first add-shift step happens on the start
// edge, so done and the final product appear combinationally during the WIDTH-th step.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntLoad = CW'(WIDTH - 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q;

  logic [WIDTH-1:0]   a_src;
  logic [2*WIDTH-1:0] p_src;
  logic [WIDTH:0]     upper;

  // P = {accumulator, remaining multiplier bits}; each step adds A if P[0] then shifts right.
  always_comb begin
    a_src  = start_i ? a_i : a_q;
    p_src  = start_i ? {{WIDTH{1'b0}}, b_i} : p_q;
    upper  = {1'b0, p_src[2*WIDTH-1:WIDTH]} + (p_src[0] ? {1'b0, a_src} : '0);
    prod_o = {upper, p_src[WIDTH-1:1]};
    done_o = busy_q && (cnt_q == CntOne);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      p_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CntLoad;
      a_q    <= a_i;
      p_q    <= prod_o;
    end else if (busy_q) begin
      p_q   <= prod_o;
      cnt_q <= cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic, bit-serial shift/rotate and an iterative
// multiplier behind a start/ready handshake with a one-cycle valid pulse on completion.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUOp_i,
  input  logic             carry_i,
  input  logic [CW-1:0]    count_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             zero_o
);

  localparam logic [CW-1:0] CntOne = CW'(1);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d, op_in;
  logic [WIDTH-1:0] sh_q, sh_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, zero_q, zero_d, valid_q, valid_d;

  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     idle_step, busy_step;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_carry;

  // Returns {bit shifted out, shifted value}; rotates report 0 and take their flag later.
  function automatic logic [WIDTH:0] shift_step(alu_op_e op, logic [WIDTH-1:0] v);
    case (op)
      OpShl:   shift_step = {v, 1'b0};
      OpShr:   shift_step = {v[0], 1'b0, v[WIDTH-1:1]};
      OpRol:   shift_step = {1'b0, v[WIDTH-2:0], v[WIDTH-1]};
      OpRor:   shift_step = {1'b0, v[0], v[WIDTH-1:1]};
      default: shift_step = {1'b0, v};
    endcase
  endfunction

  function automatic logic shift_carry(alu_op_e op, logic c, logic [WIDTH-1:0] r);
    case (op)
      OpRol:   shift_carry = r[0];
      OpRor:   shift_carry = r[WIDTH-1];
      default: shift_carry = c;
    endcase
  endfunction

  assign op_in     = alu_op_e'(ALUOp_i);
  assign ready_o   = (state_q == StIdle) && !rst_i;
  assign accept    = start_i && ready_o;
  assign idle_step = shift_step(op_in, rs_i);
  assign busy_step = shift_step(op_q, sh_q);

  // Result of any op that completes in its accept cycle.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    case (op_in)
      OpAdd:  {sc_carry, sc_res} = {1'b0, rs_i} + {1'b0, op2_i};
      OpAdc:  {sc_carry, sc_res} = {1'b0, rs_i} + {1'b0, op2_i} + {{WIDTH{1'b0}}, carry_i};
      OpSub:  {sc_carry, sc_res} = {1'b0, rs_i} - {1'b0, op2_i};
      OpSbc:  {sc_carry, sc_res} = {1'b0, rs_i} - {1'b0, op2_i} - {{WIDTH{1'b0}}, carry_i};
      OpAnd:  sc_res = rs_i & op2_i;
      OpOr:   sc_res = rs_i | op2_i;
      OpXor:  sc_res = rs_i ^ op2_i;
      OpAndn: sc_res = rs_i & ~op2_i;
      OpShl, OpShr, OpRol, OpRor: begin
        if (count_i == '0) begin
          sc_res   = rs_i;
          sc_carry = shift_carry(op_in, 1'b0, rs_i);
        end else begin
          sc_res   = idle_step[WIDTH-1:0];
          sc_carry = shift_carry(op_in, idle_step[WIDTH], idle_step[WIDTH-1:0]);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_is_multicycle(op_in, count_i > CntOne)) begin
            state_d = StBusy;
            op_d    = op_in;
            if (op_is_mul(op_in)) begin
              mul_start = 1'b1;
            end else begin
              // First shift step happens on the accept edge.
              sh_d  = idle_step[WIDTH-1:0];
              cnt_d = count_i - CntOne;
            end
          end else begin
            valid_d = 1'b1;
            res_d   = sc_res;
            carry_d = sc_carry;
          end
        end
      end
      StBusy: begin
        if (op_is_mul(op_q)) begin
          if (mul_done) begin
            state_d = StIdle;
            valid_d = 1'b1;
            if (op_q == OpMulh) begin
              res_d   = mul_prod[2*WIDTH-1:WIDTH];
              carry_d = 1'b0;
            end else begin
              res_d   = mul_prod[WIDTH-1:0];
              carry_d = |mul_prod[2*WIDTH-1:WIDTH];
            end
          end
        end else if (cnt_q == CntOne) begin
          state_d = StIdle;
          valid_d = 1'b1;
          res_d   = busy_step[WIDTH-1:0];
          carry_d = shift_carry(op_q, busy_step[WIDTH], busy_step[WIDTH-1:0]);
        end else begin
          sh_d  = busy_step[WIDTH-1:0];
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
    if (valid_d) begin
      zero_d = (res_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(mul_start),
    .a_i    (rs_i),
    .b_i    (op2_i),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  assign valid_o = valid_q;
  assign res_o   = res_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8: one task per scenario, inline checks.
module tb_alu_seq;

  logic       clk, rst, start, carry_in, ready, valid, carry, zero;
  logic [3:0] alu_op;
  logic [2:0] count;
  logic [7:0] rs, op2, res;
  int tests, fails;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [2:0] n;
    logic [7:0] res;
    logic       cy;
    logic       z;
    int         lat;
  } vec_t;

  alu_seq #(
    .WIDTH(8)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .ALUOp_i(alu_op),
    .carry_i(carry_in),
    .count_i(count),
    .rs_i   (rs),
    .op2_i  (op2),
    .ready_o(ready),
    .valid_o(valid),
    .res_o  (res),
    .carry_o(carry),
    .zero_o (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for valid; inputs are scrambled right after accept.
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [2:0] n, output int lat, output int busy);
    @(negedge clk);
    alu_op = o; rs = a; op2 = b; carry_in = c; count = n; start = 1'b1;
    lat = 0;
    busy = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        start = 1'b0; rs = ~a; op2 = ~b; carry_in = ~c; count = ~n; alu_op = 4'b0000;
      end
      lat++;
      if (!valid && !ready) busy++;
    end while (!valid && lat < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alu_op = '0; carry_in = 1'b0; count = '0; rs = '0; op2 = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b need 0", ready); end
    tests++;
    if ({valid, res, carry, zero} !== 11'h000) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b r=%h c=%b z=%b need all 0", valid, res, carry, zero);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b need 1", ready); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    alu_op = 4'b0000; rs = 8'hFF; op2 = 8'h01; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    tests++;
    if ({valid, res, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL b2b_add: got v=%b r=%h c=%b z=%b need v=1 r=00 c=1 z=1",
               valid, res, carry, zero);
    end
    alu_op = 4'b0100; rs = 8'hF0; op2 = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({valid, res, carry, zero} !== {1'b1, 8'h30, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL b2b_and: got v=%b r=%h c=%b z=%b need v=1 r=30 c=0 z=0",
               valid, res, carry, zero);
    end
    @(negedge clk);
    tests++;
    if ({valid, res} !== {1'b0, 8'h30}) begin
      fails++;
      $display("FAIL b2b_hold: got v=%b r=%h need v=0 r=30", valid, res);
    end
  endtask

  task automatic test_arith_logic();
    vec_t v[9];
    int lat, busy;
    v[0] = '{4'b0010, 8'h00, 8'h01, 1'b0, 3'd0, 8'hFF, 1'b1, 1'b0, 1};
    v[1] = '{4'b0011, 8'h05, 8'h02, 1'b1, 3'd0, 8'h02, 1'b0, 1'b0, 1};
    v[2] = '{4'b0001, 8'h7F, 8'h00, 1'b1, 3'd0, 8'h80, 1'b0, 1'b0, 1};
    v[3] = '{4'b0000, 8'h80, 8'h80, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1};
    v[4] = '{4'b0010, 8'h05, 8'h05, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1};
    v[5] = '{4'b0011, 8'h00, 8'h00, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b0, 1};
    v[6] = '{4'b0101, 8'h0F, 8'hA0, 1'b1, 3'd0, 8'hAF, 1'b0, 1'b0, 1};
    v[7] = '{4'b0110, 8'hFF, 8'h0F, 1'b0, 3'd0, 8'hF0, 1'b0, 1'b0, 1};
    v[8] = '{4'b0111, 8'hF0, 8'h3C, 1'b0, 3'd0, 8'hC0, 1'b0, 1'b0, 1};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].c, v[i].n, lat, busy);
      tests++;
      if ({res, carry, zero} !== {v[i].res, v[i].cy, v[i].z}) begin
        fails++;
        $display("FAIL arith_logic[%0d]: got r=%h c=%b z=%b need r=%h c=%b z=%b",
                 i, res, carry, zero, v[i].res, v[i].cy, v[i].z);
      end
      tests++;
      if (lat != v[i].lat) begin
        fails++;
        $display("FAIL arith_logic[%0d]_latency: got %0d need %0d", i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[7];
    int lat, busy;
    v[0] = '{4'b1000, 8'h81, 8'h00, 1'b0, 3'd3, 8'h08, 1'b0, 1'b0, 3};
    v[1] = '{4'b1011, 8'h01, 8'h00, 1'b0, 3'd1, 8'h80, 1'b1, 1'b0, 1};
    v[2] = '{4'b1001, 8'h01, 8'h00, 1'b0, 3'd0, 8'h01, 1'b0, 1'b0, 1};
    v[3] = '{4'b1010, 8'hC0, 8'h00, 1'b0, 3'd2, 8'h03, 1'b1, 1'b0, 2};
    v[4] = '{4'b1000, 8'h03, 8'h00, 1'b0, 3'd7, 8'h80, 1'b1, 1'b0, 7};
    v[5] = '{4'b1001, 8'h80, 8'h00, 1'b0, 3'd7, 8'h01, 1'b0, 1'b0, 7};
    v[6] = '{4'b1010, 8'h01, 8'h00, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0, 1};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].c, v[i].n, lat, busy);
      tests++;
      if ({res, carry, zero} !== {v[i].res, v[i].cy, v[i].z}) begin
        fails++;
        $display("FAIL shift[%0d]: got r=%h c=%b z=%b need r=%h c=%b z=%b",
                 i, res, carry, zero, v[i].res, v[i].cy, v[i].z);
      end
      tests++;
      if (lat != v[i].lat || busy != v[i].lat - 1) begin
        fails++;
        $display("FAIL shift[%0d]_latency: got lat=%0d busy=%0d need lat=%0d busy=%0d",
                 i, lat, busy, v[i].lat, v[i].lat - 1);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[5];
    int lat, busy;
    v[0] = '{4'b1100, 8'h10, 8'h10, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 8};
    v[1] = '{4'b1101, 8'h10, 8'h10, 1'b0, 3'd0, 8'h01, 1'b0, 1'b0, 8};
    v[2] = '{4'b1100, 8'h0F, 8'h11, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0, 8};
    v[3] = '{4'b1101, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'hFE, 1'b0, 1'b0, 8};
    v[4] = '{4'b1100, 8'hFF, 8'hFF, 1'b1, 3'd5, 8'h01, 1'b1, 1'b0, 8};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].c, v[i].n, lat, busy);
      tests++;
      if ({res, carry, zero} !== {v[i].res, v[i].cy, v[i].z}) begin
        fails++;
        $display("FAIL mul[%0d]: got r=%h c=%b z=%b need r=%h c=%b z=%b",
                 i, res, carry, zero, v[i].res, v[i].cy, v[i].z);
      end
      tests++;
      if (lat != v[i].lat || busy != 7) begin
        fails++;
        $display("FAIL mul[%0d]_latency: got lat=%0d busy=%0d need lat=%0d busy=7",
                 i, lat, busy, v[i].lat);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, busy, pulses;
    @(negedge clk);
    alu_op = 4'b1100; rs = 8'h0F; op2 = 8'h11; carry_in = 1'b0; count = '0; start = 1'b1;
    lat = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      rs = 8'h03; op2 = 8'h05;
      lat++;
      if (valid) pulses++;
    end while (!valid && lat < 40);
    start = 1'b0;
    tests++;
    if ({res, carry, zero} !== {8'hFF, 1'b0, 1'b0} || lat != 8) begin
      fails++;
      $display("FAIL busy_ignore_result: got r=%h c=%b z=%b lat=%0d need r=ff c=0 z=0 lat=8",
               res, carry, zero, lat);
    end
    repeat (10) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL busy_ignore_pulses: got %0d need 1", pulses);
    end
    run_op(4'b1110, 8'h55, 8'hAA, 1'b1, 3'd3, lat, busy);
    tests++;
    if ({res, carry, zero} !== {8'h00, 1'b0, 1'b1} || lat != 1) begin
      fails++;
      $display("FAIL reserved_1110: got r=%h c=%b z=%b lat=%0d need r=00 c=0 z=1 lat=1",
               res, carry, zero, lat);
    end
    run_op(4'b0000, 8'h01, 8'h01, 1'b0, 3'd0, lat, busy);
    run_op(4'b1111, 8'hFF, 8'h01, 1'b0, 3'd0, lat, busy);
    tests++;
    if ({res, carry, zero} !== {8'h00, 1'b0, 1'b1} || lat != 1) begin
      fails++;
      $display("FAIL reserved_1111: got r=%h c=%b z=%b lat=%0d need r=00 c=0 z=1 lat=1",
               res, carry, zero, lat);
    end
  endtask

  task automatic test_reset_abort();
    int lat, busy, pulses;
    run_op(4'b0000, 8'h12, 8'h34, 1'b0, 3'd0, lat, busy);
    tests++;
    if ({res, carry, zero} !== {8'h46, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_pre_add: got r=%h c=%b z=%b need r=46 c=0 z=0", res, carry, zero);
    end
    @(negedge clk);
    alu_op = 4'b1100; rs = 8'h0F; op2 = 8'h11; start = 1'b1;
    pulses = 0;
    @(negedge clk);
    start = 1'b0;
    if (valid) pulses++;
    repeat (3) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (ready !== 1'b0) begin fails++; $display("FAIL abort_ready_in_reset: got %b need 0", ready); end
    repeat (2) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready_after: got %b need 1", ready); end
    tests++;
    if ({res, carry, zero} !== {8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_zeroed: got r=%h c=%b z=%b need r=00 c=0 z=0", res, carry, zero);
    end
    repeat (10) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL abort_no_valid: got %0d pulses need 0", pulses); end
    run_op(4'b0000, 8'h03, 8'h04, 1'b0, 3'd0, lat, busy);
    tests++;
    if ({res, carry, zero} !== {8'h07, 1'b0, 1'b0} || lat != 1) begin
      fails++;
      $display("FAIL abort_post_add: got r=%h c=%b z=%b lat=%0d need r=07 c=0 z=0 lat=1",
               res, carry, zero, lat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_back_to_back();
    test_arith_logic();
    test_shift();
    test_mul();
    test_start_while_busy();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, sequential successor to the Gumnut combinational ALU. It adds a registered valid/ready start handshake and generalises the data width. It adds iterative shift and rotate (one bit per cycle) and an unsigned shift-add multiplier. It sits between the decode stage and the register-file write-back, and the control FSM stalls on ready_o.

Parameters:
WIDTH, 8, datapath width in bits; power of two, 4 or more.
CW, $clog2(WIDTH), shift-count width; derived localparam, not overridable.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  request; accepted only on a cycle where ready_o=1.
ALUOp_i  in  4  operation code (see Behaviour).
carry_i  in  1  carry/borrow input; sampled at accept.
count_i  in  CW  shift/rotate amount; sampled at accept.
rs_i  in  WIDTH  operand A; sampled at accept.
op2_i  in  WIDTH  operand B; sampled at accept.
ready_o  out  1  unit idle and able to accept.
valid_o  out  1  one-cycle pulse: res_o, carry_o and zero_o updated this cycle.
res_o  out  WIDTH  registered result; held until the next completion.
carry_o  out  1  registered carry flag.
zero_o  out  1  registered zero flag; 1 when res_o == 0.

Behaviour:
- Reset: state=IDLE; res_o=0, carry_o=0, zero_o=0, valid_o=0. ready_o=0 while rst_i=1 and 1 on the first cycle after release. Reset mid-operation aborts it with no valid_o pulse.
- Op codes:
  - 0000 ADD, 0001 ADC, 0010 SUB, 0011 SBC.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 ANDN (A & ~B).
  - 1000 SHL, 1001 SHR, 1010 ROL, 1011 ROR.
  - 1100 MUL, 1101 MULH, 1110/1111 reserved.
- Arithmetic: computed at WIDTH+1 bits; carry_o = bit WIDTH.
  - For SUB/SBC this bit is the borrow (two's-complement wrap).
  - Logic ops: carry_o=0.
- Shifts:
  - SHL: carry_o = last bit shifted out of the MSB.
  - SHR: carry_o = last bit shifted out of the LSB.
  - count=0 gives res=A and carry_o=0.
- Rotates: after rotation, ROL gives carry_o=res[0] and ROR gives carry_o=res[WIDTH-1]. count=0 gives res=A with the same carry rule.
- Multiply: unsigned, 2*WIDTH-bit product.
  - MUL: res = low half, carry_o = OR-reduce of the high half.
  - MULH: res = high half, carry_o=0.
- Reserved codes: res=0, carry_o=0, zero_o=1, single-cycle. No error flag.
- Latency L, counted from the accept edge to the valid_o cycle:
  - L=1 for ops 0000-0111 and reserved codes.
  - L=max(1,count) for shifts and rotates.
  - L=WIDTH for MUL and MULH.
- FSM IDLE/BUSY:
  - IDLE & start_i & L==1: result is registered, valid_o=1 next cycle, state stays IDLE. Back-to-back single-cycle ops run at 1 per cycle.
  - IDLE & start_i & L>1: operands are latched, iteration counter is loaded, go to BUSY.
  - BUSY: one shift bit or one add-shift step per cycle. On the final step the result is registered, valid_o=1 next cycle, and the FSM returns to IDLE.
- ready_o = (state==IDLE) & ~rst_i.
- start_i while BUSY is ignored; no queueing.
- Input changes after accept have no effect on the operation in flight.
- res_o, carry_o and zero_o change only on valid_o cycles.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum with the op codes above.
  - helper function op_is_multicycle.
  - Nothing in the package is width-dependent.
- One sub-module, alu_seq_mul: the iterative unsigned shift-add multiplier (start/done, WIDTH cycles), instanced by alu_seq.
- The shifter iterates in alu_seq's own datapath.

Test Plan:
1. ADD, A=0xFF, B=0x01, carry_i=0 -> valid_o one cycle after accept; res=0x00, carry=1, zero=1. A back-to-back AND (0xF0, 0x3C) on the next cycle -> res=0x30, carry=0, zero=0.
2. SUB, A=0x00, B=0x01 -> res=0xFF, carry=1. SBC, A=0x05, B=0x02, carry_i=1 -> res=0x02, carry=0.
3. SHL 0x81, count=3 -> ready_o=0 for 2 cycles, valid_o 3 cycles after accept; res=0x08, carry=0. ROR 0x01, count=1 -> res=0x80, carry=1. SHR 0x01, count=0 -> res=0x01, carry=0, L=1.
4. MUL 0x10×0x10 -> valid_o 8 cycles after accept; res=0x00, carry=1, zero=1. MULH with the same operands -> res=0x01, carry=0. MUL 0x0F×0x11 -> res=0xFF, carry=0.
5. start_i held high during a MUL with different operands -> ignored; exactly one valid_o, with the correct product. Reserved op 1110 -> res=0, zero=1.
6. rst_i asserted 4 cycles into a MUL -> no valid_o; outputs zeroed. ready_o=1 on the first cycle after rst_i falls, and a new ADD completes correctly.
